// File: rtl/sm_mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port among N requesters,
// with per-access watchdog abort.
module sm_mem_arbiter #(
  parameter int unsigned N       = 3,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*AW-1:0] addr,
  input  logic [N*32-1:0] wdata,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic [31:0]     rdata,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata
);

  localparam int unsigned   IDXW     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned   CW       = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [N-1:0]  ONE_HOT0 = N'(1);
  localparam bit            WDOG_EN  = (TIMEOUT != 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    done_q, done_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] cand;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [31:0]     win_wdata;

  // Round-robin search starting one past the last granted index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IDXW'((32'(ptr_q) + i) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Payload mux for the winning requester.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (win_idx == IDXW'(k)) begin
        win_we    = we[k];
        win_addr  = addr[k*AW +: AW];
        win_wdata = wdata[k*32 +: 32];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    done_d      = '0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = BUSY;
          ptr_d       = win_idx;
          owner_d     = win_idx;
          cnt_d       = '0;
          gnt_d       = ONE_HOT0 << win_idx;
          mem_req_d   = 1'b1;
          mem_we_d    = win_we;
          mem_addr_d  = win_addr;
          mem_wdata_d = win_wdata;
        end
      end
      BUSY: begin
        mem_req_d = 1'b1;
        // An ack on the watchdog's final cycle still completes normally.
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          done_d    = ONE_HOT0 << owner_q;
          rdata_d   = mem_we_q ? 32'd0 : mem_rdata;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          done_d    = ONE_HOT0 << owner_q;
          err_d     = 1'b1;
          rdata_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= LAST_IDX;
      owner_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/sm_mem_arbiter.md
# sm_mem_arbiter

Shared single-port memory arbiter for the schoolMIPS core. N requesters share one variable-latency memory port through a round-robin scheduler. Typical requesters are instruction fetch, data load/store and the debug/DIP loader. The block serializes accesses, holds the memory request stable until the memory acknowledges, returns read data and a completion pulse to the owner, and aborts hung accesses with a watchdog.

## Interface
- N, 3, number of requesters (2..8)
- AW, 32, word-address width (word addressing, as the core's pc)
- TIMEOUT, 16, max BUSY cycles before abort; 0 disables watchdog; ≤ 65535
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N  per-requester access request
- we  in  N  per-requester write enable (1 = write, 0 = read)
- addr  in  N*AW  packed addresses, requester k at [k*AW +: AW]
- wdata  in  N*32  packed write data, requester k at [k*32 +: 32]
- gnt  out  N  one-hot, one-cycle grant pulse
- done  out  N  one-hot, one-cycle completion pulse
- rdata  out  32  read data, valid while done is high and the op was a read
- err  out  1  high with done when the access was aborted by the watchdog
- mem_req  out  1  memory request, held until acknowledged or aborted
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory completion, sampled only while mem_req = 1
- mem_rdata  in  32  memory read data, valid with mem_ack

## Operation
- Two-state FSM: IDLE, BUSY. Reset state IDLE.
- IDLE with any req bit set: select a winner round-robin. Search starts at index ptr+1 mod N, where ptr is the last granted index.
- On the IDLE clock edge that has a winner:
  - register owner, we/addr/wdata of the winner, gnt[owner] = 1 for the next cycle;
  - set ptr = owner, clear the timeout counter, enter BUSY.
- IDLE with no req: stay in IDLE. ptr is unchanged.
- BUSY: mem_req = 1. mem_we/addr/wdata come from the latched registers and are stable for the whole BUSY period.
- BUSY with mem_ack = 1 at an edge: capture mem_rdata into rdata (reads only; writes leave rdata = 0). Pulse done[owner] with err = 0 in the next cycle and return to IDLE.
- BUSY without mem_ack: the counter increments. If TIMEOUT ≠ 0 and the counter is TIMEOUT-1 at an edge, abort: pulse done[owner] with err = 1, set rdata = 0, return to IDLE.
- mem_ack and watchdog expiry at the same edge: the ack wins (normal completion, err = 0).
- mem_ack while in IDLE is ignored.
- Requester rule: hold req, we, addr and wdata stable until gnt is seen high. After that they may change. A requester may re-request in the cycle its done pulses.
- req dropped before grant: that requester is no longer eligible. No grant is issued for it.
- Reset at any time, including mid-BUSY:
  - all outputs 0 immediately, FSM to IDLE, ptr = N-1 (requester 0 wins first);
  - the in-flight access is dropped with no done. Memory must tolerate mem_req deasserting without ack.

## Timing
- Reset values: gnt = 0, done = 0, rdata = 0, err = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- req high in cycle T (IDLE): gnt and mem_req high in T+1.
- Zero-wait memory (mem_ack high in T+1): done in T+2. Arbitration also occurs in T+2, so the next gnt/mem_req is at T+3.
  - Peak throughput is 1 access per 2 cycles.
  - Request-to-done latency is 2 + W cycles for W wait states.
- BUSY lasts at most TIMEOUT cycles. mem_req is high for exactly TIMEOUT cycles on abort.
- gnt and done are never high for more than 1 consecutive cycle. At most one bit of each is set.
- All outputs are registered. No combinational path from req or mem_ack to any output.

## Test plan
- Single read, zero-wait: req[0] = 1 at T with addr 0x10, mem_ack = 1 with mem_rdata 0x12345678 in T+1. Expect gnt[0] and mem_req in T+1, mem_addr = 0x10, done[0] in T+2, rdata = 0x12345678, err = 0.
- Round-robin: req = 3'b111 held, zero-wait memory. Expect grant order 0, 1, 2, 0, 1, 2, gnts 2 cycles apart. Then drop req[1]: order becomes 0, 2, 0, 2.
- Write with waits: req[2], we[2] = 1, addr 0x40, wdata 0xCAFEF00D, ack after 3 wait states. Expect mem_req high 4 cycles with fields stable, done[2] the cycle after ack, rdata = 0, err = 0.
- Watchdog: TIMEOUT = 16, mem_ack never asserted. Expect mem_req high exactly 16 cycles, then done[owner] with err = 1 and rdata = 0; the next request is granted normally.
- Ack on the last cycle: mem_ack arrives in the 16th BUSY cycle. Expect normal completion with err = 0 and rdata = mem_rdata.
- Reset mid-BUSY: assert rst during a wait state. Expect mem_req/gnt/done low without a clock edge and no done for the dropped access. After release, with req[0] and req[1] both high, expect gnt[0] first.
